// File: rtl/simpletron_pkg.sv
// Shared definitions for the Simpletron core: opcodes, FSM states,
// ALU operations and instruction field helpers.
package simpletron_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int OPC_W  = 3;

  localparam logic [OPC_W-1:0] OP_HALT  = 3'b000;
  localparam logic [OPC_W-1:0] OP_BR    = 3'b001;
  localparam logic [OPC_W-1:0] OP_BZ    = 3'b010;
  localparam logic [OPC_W-1:0] OP_ILL   = 3'b011;
  localparam logic [OPC_W-1:0] OP_ADD   = 3'b100;
  localparam logic [OPC_W-1:0] OP_SUB   = 3'b101;
  localparam logic [OPC_W-1:0] OP_LOAD  = 3'b110;
  localparam logic [OPC_W-1:0] OP_STORE = 3'b111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_PASS = 2'd2
  } alu_op_e;

  function automatic logic [OPC_W-1:0] opc_of(
    input logic [DATA_W-1:0] w
  );
    return w[DATA_W-1 -: OPC_W];
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [DATA_W-1:0] w
  );
    return w[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/simpletron_alu.sv
// Accumulator datapath for the Simpletron core.
// Pure combinational add / sub / pass-through, wrapping, no flags.
module simpletron_alu
  import simpletron_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  alu_op_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = b;
    unique case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_PASS: y = b;
      default:  y = b;
    endcase
  end

endmodule

// File: rtl/simpletron_controller.sv
// Simpletron control unit: PC/IR/ACC, fetch/execute sequencing and
// host peek/poke arbitration of the shared memory port while halted.
module simpletron_controller
  import simpletron_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int DATA_W_P = DATA_W,
  parameter int START_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W_P-1:0] mem_addr,
  output logic                mem_we,
  output logic [DATA_W_P-1:0] mem_wdata,
  input  logic [DATA_W_P-1:0] mem_rdata,
  input  logic                resume,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [ADDR_W_P-1:0] host_addr,
  input  logic [DATA_W_P-1:0] host_wdata,
  output logic                host_gnt,
  output logic [DATA_W_P-1:0] host_rdata,
  output logic [ADDR_W_P-1:0] pc,
  output logic [DATA_W_P-1:0] ir,
  output logic [DATA_W_P-1:0] acc,
  output logic                halted,
  output logic                illegal,
  output logic [15:0]         retired
);

  localparam logic [ADDR_W_P-1:0] PC0 = ADDR_W_P'(START_PC);

  state_e              state_q, state_d;
  logic [ADDR_W_P-1:0] pc_q, pc_d;
  logic [DATA_W_P-1:0] ir_q, ir_d;
  logic [DATA_W_P-1:0] acc_q, acc_d;
  logic                illegal_q, illegal_d;
  logic [15:0]         retired_q, retired_d;

  logic [OPC_W-1:0]    opc;
  logic [ADDR_W_P-1:0] op_addr;
  alu_op_e             alu_op;
  logic [DATA_W_P-1:0] alu_y;

  simpletron_alu #(.W(DATA_W_P)) u_alu (
    .op (alu_op),
    .a  (acc_q),
    .b  (mem_rdata),
    .y  (alu_y)
  );

  assign opc     = opc_of(ir_q);
  assign op_addr = addr_of(ir_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    alu_op    = ALU_PASS;
    mem_addr  = pc_q;
    mem_we    = 1'b0;
    mem_wdata = acc_q;
    host_gnt  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        mem_addr = op_addr;
        state_d  = S_FETCH;
        if (retired_q != 16'hFFFF)
          retired_d = retired_q + 16'd1;
        unique case (opc)
          OP_HALT: state_d = S_HALT;
          OP_BR:   pc_d = op_addr;
          OP_BZ: begin
            if (acc_q == '0)
              pc_d = op_addr;
          end
          OP_ILL: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          OP_ADD: begin
            alu_op = ALU_ADD;
            acc_d  = alu_y;
          end
          OP_SUB: begin
            alu_op = ALU_SUB;
            acc_d  = alu_y;
          end
          OP_LOAD: begin
            alu_op = ALU_PASS;
            acc_d  = alu_y;
          end
          OP_STORE: mem_we = 1'b1;
        endcase
      end
      S_HALT: begin
        // resume outranks a same-cycle host request
        if (resume) begin
          pc_d      = PC0;
          acc_d     = '0;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end else if (host_req) begin
          host_gnt  = 1'b1;
          mem_addr  = host_addr;
          mem_we    = host_we;
          mem_wdata = host_wdata;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= PC0;
      ir_q      <= '0;
      acc_q     <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign host_rdata = mem_rdata;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign acc        = acc_q;
  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule
